// File: rtl/exe_hilo_pkg.sv
// Shared op codes, engine state encoding and op-class decode for the EXE HI/LO unit.
// The fast-multiply option (EXE_FAST_MUL_EN) is selected in exe_hilo_unit.
package exe_hilo_pkg;

  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  function automatic logic is_hilo_op(input logic [5:0] code);
    case (code)
      OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exe_hilo_divstep.sv
// One restoring-divide step: shift the next dividend bit into the partial remainder,
// subtract the divisor if it fits, and shift the resulting quotient bit in.
module exe_hilo_divstep
  import exe_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quot
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  assign w_shifted = {i_rem, i_quot[WIDTH-1]};
  assign w_diff    = w_shifted - {1'b0, i_divisor};

  // Top bit of the difference acts as the borrow: set means the divisor did not fit.
  always_comb begin
    o_rem  = w_diff[WIDTH-1:0];
    o_quot = {i_quot[WIDTH-2:0], 1'b1};
    if (w_diff[WIDTH]) begin
      o_rem  = w_shifted[WIDTH-1:0];
      o_quot = {i_quot[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/exe_hilo_unit.sv
// EXE-side HI/LO unit: MFHI/MFLO/MTHI/MTLO plus iterative radix-2 multiply and divide.
// Mul/div take 32 cycles after accept (EXE_FAST_MUL_EN: multiply writes HI/LO at accept).
// WANT_FREEZE holds ID while a HI/LO op meets a busy engine; stall_IC blocks accept and holds results.
module exe_hilo_unit
  import exe_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             stall_IC,
  input  logic [5:0]       ALU_Control1_IN,
  input  logic [WIDTH-1:0] OperandA1_IN,
  input  logic [WIDTH-1:0] OperandB1_IN,
  input  logic [WIDTH-1:0] Instr1_IN,
  output logic [WIDTH-1:0] Result_OUT,
  output logic             ResultValid_OUT,
  output logic             Busy_OUT,
  output logic             WANT_FREEZE,
  output logic [WIDTH-1:0] HI_OUT,
  output logic [WIDTH-1:0] LO_OUT
);

  state_t r_state;
  state_t w_state_nxt;

  logic [5:0]         r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_mcand;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_dz;
  logic [WIDTH-1:0]   r_result;
  logic               r_result_vld;

  logic               w_hilo_op;
  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_is_signed;
  logic               w_load;
  logic               w_last;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   w_mul_hi;
  logic [WIDTH-1:0]   w_mul_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_div_rem;
  logic [WIDTH-1:0]   w_div_quot;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_unused_instr;

  assign w_unused_instr = Instr1_IN;

  assign w_hilo_op   = is_hilo_op(ALU_Control1_IN);
  assign WANT_FREEZE = w_hilo_op && (r_state != IDLE);
  assign w_accept    = w_hilo_op && !WANT_FREEZE && !stall_IC;

  assign w_is_mul    = (ALU_Control1_IN == OP_MULT) || (ALU_Control1_IN == OP_MULTU);
  assign w_is_div    = (ALU_Control1_IN == OP_DIV)  || (ALU_Control1_IN == OP_DIVU);
  assign w_is_signed = (ALU_Control1_IN == OP_MULT) || (ALU_Control1_IN == OP_DIV);

`ifdef EXE_FAST_MUL_EN
  assign w_load = w_accept && w_is_div;
`else
  assign w_load = w_accept && (w_is_div || w_is_mul);
`endif

  assign w_a_neg = w_is_signed && OperandA1_IN[WIDTH-1];
  assign w_b_neg = w_is_signed && OperandB1_IN[WIDTH-1];
  assign w_a_mag = w_a_neg ? -OperandA1_IN : OperandA1_IN;
  assign w_b_mag = w_b_neg ? -OperandB1_IN : OperandB1_IN;

`ifdef EXE_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_mag;
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_mag  = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
  assign w_fast_prod = (w_a_neg ^ w_b_neg) ? -w_fast_mag : w_fast_mag;
`endif

  assign w_last = (r_cnt == 6'd31);

  // Shift-add step: r_acc_lo starts as the multiplier and fills with product bits from the top.
  assign w_mul_sum  = {1'b0, r_acc_hi} + {1'b0, (r_acc_lo[0] ? r_mcand : {WIDTH{1'b0}})};
  assign w_mul_hi   = w_mul_sum[WIDTH:1];
  assign w_mul_lo   = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
  assign w_prod     = {w_mul_hi, w_mul_lo};
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;

  exe_hilo_divstep #(
    .WIDTH (WIDTH)
  ) u_divstep (
    .i_rem     (r_acc_hi),
    .i_quot    (r_acc_lo),
    .i_divisor (r_mcand),
    .o_rem     (w_div_rem),
    .o_quot    (w_div_quot)
  );

  // Divide by zero leaves the dividend magnitude in the remainder, so only LO needs forcing.
  assign w_quot_fix = r_dz ? {WIDTH{1'b1}} : (r_neg_res ? -w_div_quot : w_div_quot);
  assign w_rem_fix  = r_neg_rem ? -w_div_rem : w_div_rem;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_div) begin
          w_state_nxt = DIV;
        end
`ifndef EXE_FAST_MUL_EN
        else if (w_accept && w_is_mul) begin
          w_state_nxt = MUL;
        end
`endif
      end
      MUL, DIV: begin
        if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt        <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_acc_hi     <= '0;
      r_acc_lo     <= '0;
      r_mcand      <= '0;
      r_neg_res    <= 1'b0;
      r_neg_rem    <= 1'b0;
      r_dz         <= 1'b0;
      r_result     <= '0;
      r_result_vld <= 1'b0;
    end else begin
      if (r_state != IDLE) begin
        r_cnt <= w_last ? 6'd0 : r_cnt + 6'd1;
        if (r_state == MUL) begin
          r_acc_hi <= w_mul_hi;
          r_acc_lo <= w_mul_lo;
          if (w_last) {r_hi, r_lo} <= w_prod_fix;
        end else begin
          r_acc_hi <= w_div_rem;
          r_acc_lo <= w_div_quot;
          if (w_last) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quot_fix;
          end
        end
      end

      if (w_load) begin
        r_cnt     <= '0;
        r_acc_hi  <= '0;
        r_acc_lo  <= w_a_mag;
        r_mcand   <= w_b_mag;
        r_neg_res <= w_a_neg ^ w_b_neg;
        r_neg_rem <= w_a_neg;
        r_dz      <= (OperandB1_IN == '0);
      end

      if (!stall_IC) r_result_vld <= 1'b0;

      if (w_accept) begin
        case (ALU_Control1_IN)
          OP_MFHI: begin
            r_result     <= r_hi;
            r_result_vld <= 1'b1;
          end
          OP_MFLO: begin
            r_result     <= r_lo;
            r_result_vld <= 1'b1;
          end
          OP_MTHI: r_hi <= OperandA1_IN;
          OP_MTLO: r_lo <= OperandA1_IN;
`ifdef EXE_FAST_MUL_EN
          OP_MULT, OP_MULTU: {r_hi, r_lo} <= w_fast_prod;
`endif
          default: ;
        endcase
      end
    end
  end

  assign Result_OUT      = r_result;
  assign ResultValid_OUT = r_result_vld;
  assign Busy_OUT        = (r_state != IDLE);
  assign HI_OUT          = r_hi;
  assign LO_OUT          = r_lo;

endmodule

// File: tb/tb_exe_hilo_unit.sv
// Directed bench for exe_hilo_unit: hand-computed HI/LO, result and freeze timing checks.
module tb_exe_hilo_unit;
  import exe_hilo_pkg::*;

  localparam logic [5:0] OP_NOP = 6'b100000;
`ifdef EXE_FAST_MUL_EN
  localparam int MUL_CYC = 0;
`else
  localparam int MUL_CYC = 32;
`endif
  localparam int DIV_CYC = 32;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        stall_IC;
  logic [5:0]  ALU_Control1_IN;
  logic [31:0] OperandA1_IN;
  logic [31:0] OperandB1_IN;
  logic [31:0] Instr1_IN;
  logic [31:0] Result_OUT;
  logic        ResultValid_OUT;
  logic        Busy_OUT;
  logic        WANT_FREEZE;
  logic [31:0] HI_OUT;
  logic [31:0] LO_OUT;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  exe_hilo_unit #(.WIDTH(32)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .stall_IC        (stall_IC),
    .ALU_Control1_IN (ALU_Control1_IN),
    .OperandA1_IN    (OperandA1_IN),
    .OperandB1_IN    (OperandB1_IN),
    .Instr1_IN       (Instr1_IN),
    .Result_OUT      (Result_OUT),
    .ResultValid_OUT (ResultValid_OUT),
    .Busy_OUT        (Busy_OUT),
    .WANT_FREEZE     (WANT_FREEZE),
    .HI_OUT          (HI_OUT),
    .LO_OUT          (LO_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents one op for one edge, then counts cycles until the engine is idle again.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit stall_mid, output int n);
    ALU_Control1_IN = op;
    OperandA1_IN    = a;
    OperandB1_IN    = b;
    tick();
    ALU_Control1_IN = OP_NOP;
    n = 0;
    while (Busy_OUT && n < 40) begin
      stall_IC = stall_mid && (n >= 4) && (n < 9);
      tick();
      n++;
    end
    stall_IC = 1'b0;
  endtask

  initial begin
    RESET           = 1'b1;
    stall_IC        = 1'b0;
    ALU_Control1_IN = OP_NOP;
    OperandA1_IN    = '0;
    OperandB1_IN    = '0;
    Instr1_IN       = 32'h0000_0018;
    tick();
    tick();
    RESET = 1'b0;
    chk("rst_hi", HI_OUT, 32'h0);
    chk("rst_lo", LO_OUT, 32'h0);
    chk("rst_res", Result_OUT, 32'h0);
    chk("rst_vld", {31'b0, ResultValid_OUT}, 32'h0);
    chk("rst_busy", {31'b0, Busy_OUT}, 32'h0);
    chk("rst_frz", {31'b0, WANT_FREEZE}, 32'h0);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0, cyc);
    chk("multu_cyc", cyc, MUL_CYC);
    chk("multu_hi", HI_OUT, 32'h0000_0001);
    chk("multu_lo", LO_OUT, 32'hFFFF_FFFE);

    // stall_IC mid-run must not slow the engine
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'h7, 1'b1, cyc);
    chk("mult_cyc", cyc, MUL_CYC);
    chk("mult_hi", HI_OUT, 32'hFFFF_FFFF);
    chk("mult_lo", LO_OUT, 32'hFFFF_FFEB);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b1, cyc);
    chk("div_cyc", cyc, DIV_CYC);
    chk("div_lo", LO_OUT, 32'hFFFF_FFFD);
    chk("div_hi", HI_OUT, 32'hFFFF_FFFF);

    run_op(OP_DIVU, 32'h0000_1234, 32'h0, 1'b0, cyc);
    chk("divu0_cyc", cyc, DIV_CYC);
    chk("divu0_lo", LO_OUT, 32'hFFFF_FFFF);
    chk("divu0_hi", HI_OUT, 32'h0000_1234);

    run_op(OP_DIV, 32'hFFFF_FFFB, 32'h0, 1'b0, cyc);
    chk("div0_lo", LO_OUT, 32'hFFFF_FFFF);
    chk("div0_hi", HI_OUT, 32'hFFFF_FFFB);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc);
    chk("divovf_lo", LO_OUT, 32'h8000_0000);
    chk("divovf_hi", HI_OUT, 32'h0000_0000);

    // DIVU then MFLO immediately: MFLO is frozen for the whole 32-cycle engine occupancy
    ALU_Control1_IN = OP_DIVU;
    OperandA1_IN    = 32'd100;
    OperandB1_IN    = 32'd7;
    tick();
    ALU_Control1_IN = OP_MFLO;
    #1;
    cyc = 0;
    while (WANT_FREEZE && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("frz_cyc", cyc, 32);
    tick();
    chk("mflo_q", Result_OUT, 32'd14);
    chk("mflo_vld", {31'b0, ResultValid_OUT}, 32'h1);
    ALU_Control1_IN = OP_MFHI;
    tick();
    chk("mfhi_r", Result_OUT, 32'd2);
    ALU_Control1_IN = OP_NOP;
    tick();
    chk("vld_drop", {31'b0, ResultValid_OUT}, 32'h0);

    ALU_Control1_IN = OP_MTLO;
    OperandA1_IN    = 32'hCAFE_F00D;
    tick();
    chk("mtlo_lo", LO_OUT, 32'hCAFE_F00D);
    ALU_Control1_IN = OP_MFLO;
    tick();
    chk("mtlo_mflo", Result_OUT, 32'hCAFE_F00D);

    stall_IC        = 1'b1;
    ALU_Control1_IN = OP_MTLO;
    OperandA1_IN    = 32'h1111_1111;
    #1;
    chk("stall_frz", {31'b0, WANT_FREEZE}, 32'h0);
    tick();
    chk("stall_lo", LO_OUT, 32'hCAFE_F00D);
    ALU_Control1_IN = OP_MFHI;
    tick();
    chk("stall_res", Result_OUT, 32'hCAFE_F00D);
    chk("stall_vld", {31'b0, ResultValid_OUT}, 32'h1);
    stall_IC = 1'b0;
    tick();
    chk("unstall_mfhi", Result_OUT, 32'd2);
    ALU_Control1_IN = OP_NOP;
    tick();

    // Reset part-way through a divide discards it
    ALU_Control1_IN = OP_DIV;
    OperandA1_IN    = 32'd1000;
    OperandB1_IN    = 32'd3;
    tick();
    ALU_Control1_IN = OP_NOP;
    #1;
    chk("nop_nofrz", {31'b0, WANT_FREEZE}, 32'h0);
    chk("div_busy", {31'b0, Busy_OUT}, 32'h1);
    ALU_Control1_IN = OP_DIVU;
    #1;
    chk("second_frz", {31'b0, WANT_FREEZE}, 32'h1);
    ALU_Control1_IN = OP_NOP;
    for (int i = 0; i < 10; i++) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("mid_rst_busy", {31'b0, Busy_OUT}, 32'h0);
    chk("mid_rst_hi", HI_OUT, 32'h0);
    chk("mid_rst_lo", LO_OUT, 32'h0);
    ALU_Control1_IN = OP_MFHI;
    tick();
    chk("post_rst_mfhi", Result_OUT, 32'h0);
    chk("post_rst_vld", {31'b0, ResultValid_OUT}, 32'h1);
    ALU_Control1_IN = OP_NOP;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
